conv_window_sequencer: RTL and testbench

//  Sequences one convolution layer pass of the CNN datapath: loads KxK weights, then streams an
//  IF_SIZE x IF_SIZE feature map in raster order (stride 1, no padding) and tags each valid window.

---
 rtl/cnn_ctrl_pkg.sv | 21 ++
 rtl/ctrl_delay_line.sv | 32 +++
 rtl/conv_window_sequencer.sv | 146 ++++++++++++++
 tb/tb_conv_window_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and width helpers for the CNN layer-pass control blocks.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Index width for n items; a single-item range still needs one bit.
  function automatic int calc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int kk(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register with synchronous clear; tail stage is the registered output.
module ctrl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] r_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) r_q <= '0;
          else     r_q <= i_d;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (rst) r_q <= '0;
          else     r_q <= g_stage[gi-1].r_q;
        end
      end
    end
  endgenerate

  assign o_q = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/conv_window_sequencer.sv
// Layer-pass sequencer: weight load, raster pixel stream with window tagging,
// and pipeline-aligned strobes for the conv engine.
module conv_window_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int I_BW     = 8,
  parameter int IF_SIZE  = 28,
  parameter int K_SIZE   = 3,
  parameter int PIPE_LAT = 3,
  localparam int W_ADDR_W = calc_w(kk(K_SIZE)),
  localparam int COORD_W  = calc_w(IF_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  output logic                o_w_load,
  output logic [W_ADDR_W-1:0] o_w_addr,
  output logic                o_ce,
  output logic                o_win_valid,
  output logic [COORD_W-1:0]  o_row,
  output logic [COORD_W-1:0]  o_col,
  output logic                o_busy,
  output logic                o_done
);

  localparam int KK    = kk(K_SIZE);
  localparam int DRN_W = calc_w(PIPE_LAT);
  localparam int DW    = 2 + 2 * COORD_W;

  localparam logic [W_ADDR_W-1:0] W_LAST   = W_ADDR_W'(KK - 1);
  localparam logic [COORD_W-1:0]  C_LAST   = COORD_W'(IF_SIZE - 1);
  localparam logic [COORD_W-1:0]  C_KM1    = COORD_W'(K_SIZE - 1);
  localparam logic [DRN_W-1:0]    DRN_LAST = DRN_W'(PIPE_LAT - 1);

  generate
    if (I_BW < 1 || K_SIZE < 1 || IF_SIZE < K_SIZE || PIPE_LAT < 1) begin : g_param_check
      $error("conv_window_sequencer: illegal parameter set");
    end
  endgenerate

  state_t                r_state, w_state_next;
  logic [W_ADDR_W-1:0]   r_w_addr;
  logic [COORD_W-1:0]    r_row, r_col;
  logic [COORD_W-1:0]    r_hold_row, r_hold_col;
  logic [DRN_W-1:0]      r_drain;

  logic                  w_accept, w_win, w_last_px;
  logic                  w_row_last, w_col_last;
  logic [COORD_W-1:0]    w_out_row, w_out_col;
  logic [DW-1:0]         w_din, w_dq;

  assign w_accept   = (r_state == STREAM) && i_in_valid;
  assign w_row_last = (r_row == C_LAST);
  assign w_col_last = (r_col == C_LAST);
  assign w_last_px  = w_accept && w_row_last && w_col_last;
  assign w_win      = w_accept && (int'(r_row) >= K_SIZE - 1) && (int'(r_col) >= K_SIZE - 1);
  assign w_out_row  = r_row - C_KM1;
  assign w_out_col  = r_col - C_KM1;

  // Non-window slots carry the last window's coordinates so the tail holds them.
  assign w_din = {w_accept, w_win,
                  w_win ? w_out_row : r_hold_row,
                  w_win ? w_out_col : r_hold_col};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_w_addr   <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_hold_row <= '0;
      r_hold_col <= '0;
      r_drain    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == LOAD_W) begin
        r_w_addr <= (r_w_addr == W_LAST) ? '0 : r_w_addr + 1'b1;
      end
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_win) begin
        r_hold_row <= w_out_row;
        r_hold_col <= w_out_col;
      end
      if (r_state == DRAIN) begin
        r_drain <= (r_drain == DRN_LAST) ? '0 : r_drain + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_w_load     = 1'b0;
    o_in_ready   = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_next = LOAD_W;
      end
      LOAD_W: begin
        o_w_load = 1'b1;
        if (r_w_addr == W_LAST) w_state_next = STREAM;
      end
      STREAM: begin
        o_in_ready = 1'b1;
        if (w_last_px) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (r_drain == DRN_LAST) w_state_next = DONE;
      end
      DONE: begin
        o_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        o_busy       = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_w_addr = r_w_addr;

  ctrl_delay_line #(
    .WIDTH (DW),
    .DEPTH (PIPE_LAT)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .i_d (w_din),
    .o_q (w_dq)
  );

  assign {o_ce, o_win_valid, o_row, o_col} = w_dq;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench: four sequencer instances (default, 5x5/K3, 4x4/K1, 3x3/K3) share clock and reset.
module tb_conv_window_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [3:0] start_v;
  logic [3:0] ready_v, wload_v, ce_v, win_v, busy_v, done_v;
  logic [3:0] waddr0, waddr1, waddr3;
  logic       waddr2;
  logic [4:0] row0, col0;
  logic [2:0] row1, col1;
  logic [1:0] row2, col2, row3, col3;
  logic [7:0] waddr_v [4];
  logic [7:0] row_v   [4];
  logic [7:0] col_v   [4];

  assign waddr_v[0] = {4'b0, waddr0};
  assign waddr_v[1] = {4'b0, waddr1};
  assign waddr_v[2] = {7'b0, waddr2};
  assign waddr_v[3] = {4'b0, waddr3};
  assign row_v[0] = {3'b0, row0};
  assign col_v[0] = {3'b0, col0};
  assign row_v[1] = {5'b0, row1};
  assign col_v[1] = {5'b0, col1};
  assign row_v[2] = {6'b0, row2};
  assign col_v[2] = {6'b0, col2};
  assign row_v[3] = {6'b0, row3};
  assign col_v[3] = {6'b0, col3};

  conv_window_sequencer u_dut0 (
    .clk(clk), .rst(rst), .i_start(start_v[0]), .i_in_valid(in_valid),
    .o_in_ready(ready_v[0]), .o_w_load(wload_v[0]), .o_w_addr(waddr0),
    .o_ce(ce_v[0]), .o_win_valid(win_v[0]), .o_row(row0), .o_col(col0),
    .o_busy(busy_v[0]), .o_done(done_v[0]));

  conv_window_sequencer #(.I_BW(8), .IF_SIZE(5), .K_SIZE(3), .PIPE_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start_v[1]), .i_in_valid(in_valid),
    .o_in_ready(ready_v[1]), .o_w_load(wload_v[1]), .o_w_addr(waddr1),
    .o_ce(ce_v[1]), .o_win_valid(win_v[1]), .o_row(row1), .o_col(col1),
    .o_busy(busy_v[1]), .o_done(done_v[1]));

  conv_window_sequencer #(.I_BW(8), .IF_SIZE(4), .K_SIZE(1), .PIPE_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst), .i_start(start_v[2]), .i_in_valid(in_valid),
    .o_in_ready(ready_v[2]), .o_w_load(wload_v[2]), .o_w_addr(waddr2),
    .o_ce(ce_v[2]), .o_win_valid(win_v[2]), .o_row(row2), .o_col(col2),
    .o_busy(busy_v[2]), .o_done(done_v[2]));

  conv_window_sequencer #(.I_BW(8), .IF_SIZE(3), .K_SIZE(3), .PIPE_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_start(start_v[3]), .i_in_valid(in_valid),
    .o_in_ready(ready_v[3]), .o_w_load(wload_v[3]), .o_w_addr(waddr3),
    .o_ce(ce_v[3]), .o_win_valid(win_v[3]), .o_row(row3), .o_col(col3),
    .o_busy(busy_v[3]), .o_done(done_v[3]));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int st_cyc = 0;

  // Output side of each instance, and the coordinate (row*256+col) preceding (0,0).
  int n_side [4] = '{26, 3, 4, 1};
  int prev_rc [4] = '{25*256+25, 2*256+2, 3*256+3, 0};
  int acc_cnt [4] = '{default:0};
  int last_acc_cyc [4] = '{default:0};
  int ce_cnt [4] = '{default:0};
  int win_cnt [4] = '{default:0};
  int misalign [4] = '{default:0};
  int seq_err [4] = '{default:0};
  int first_rc [4] = '{default:0};
  int last_rc [4] = '{default:0};
  int win_ce_idx [4] = '{default:0};
  int wl_cyc_cnt [4] = '{default:0};
  int wl_rise_cnt [4] = '{default:0};
  int wl_rise_cyc [4] = '{default:0};
  int wl_idx [4] = '{default:0};
  int wl_addr_err [4] = '{default:0};
  int done_cnt [4] = '{default:0};
  int done_cyc [4] = '{default:0};
  logic [2:0] acc_sr [4] = '{default:3'b0};
  logic [3:0] wl_prev = 4'b0;
  logic [3:0] got_first = 4'b0;

  function automatic int next_rc(input int prev, input int n);
    int r, c;
    r = prev / 256;
    c = prev % 256;
    if (c == n - 1) begin
      c = 0;
      r = (r == n - 1) ? 0 : r + 1;
    end else begin
      c = c + 1;
    end
    return r * 256 + c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must trail its accept by exactly three cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (in_valid && ready_v[i] && !rst) begin
        acc_cnt[i]      <= acc_cnt[i] + 1;
        last_acc_cyc[i] <= cyc;
      end
      if ((ce_v[i] != acc_sr[i][2]) || (win_v[i] && !ce_v[i]))
        misalign[i] <= misalign[i] + 1;
      acc_sr[i] <= rst ? 3'b0 : {acc_sr[i][1:0], in_valid & ready_v[i]};
      if (ce_v[i]) ce_cnt[i] <= ce_cnt[i] + 1;
      if (win_v[i]) begin
        win_cnt[i]    <= win_cnt[i] + 1;
        win_ce_idx[i] <= ce_cnt[i] + 1;
        if (int'({row_v[i], col_v[i]}) != next_rc(prev_rc[i], n_side[i]))
          seq_err[i] <= seq_err[i] + 1;
        prev_rc[i] <= int'({row_v[i], col_v[i]});
        last_rc[i] <= int'({row_v[i], col_v[i]});
        if (!got_first[i]) first_rc[i] <= int'({row_v[i], col_v[i]});
        got_first[i] <= 1'b1;
      end
      if (wload_v[i]) begin
        wl_cyc_cnt[i] <= wl_cyc_cnt[i] + 1;
        if (int'(waddr_v[i]) != wl_idx[i]) wl_addr_err[i] <= wl_addr_err[i] + 1;
        wl_idx[i] <= wl_idx[i] + 1;
        if (!wl_prev[i]) begin
          wl_rise_cnt[i] <= wl_rise_cnt[i] + 1;
          wl_rise_cyc[i] <= cyc;
          got_first[i]   <= 1'b0;
        end
      end else begin
        wl_idx[i] <= 0;
      end
      wl_prev[i] <= wload_v[i];
      if (done_v[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      $display("ok   %s observed=%0d", tag, obs);
    end
  endtask

  task automatic start_pass(input int idx);
    @(posedge clk); #1;
    start_v[idx] = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input bit rnd);
    int snap;
    bit ok;
    snap = done_cnt[idx];
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(posedge clk); #1;
      if (rnd) in_valid = 1'($urandom_range(0, 1));
      if (done_cnt[idx] != snap) ok = 1'b1;
    end
    in_valid = 1'b1;
    chk("done_seen", int'(ok), 1);
  endtask

  initial begin
    int s_ce, s_win, s_wlc, s_wr, s_wae, s_mis, s_seq, s_acc, s_done, d1;
    bit hit;

    rst = 1'b1;
    in_valid = 1'b0;
    start_v = 4'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;

    // 1: idle after reset, pixels offered without a start
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("t1_outputs_zero", int'({ready_v[0], wload_v[0], waddr0, ce_v[0], win_v[0],
                                    row0, col0, busy_v[0], done_v[0]}), 0);
    end
    chk("t1_ready_no_start", int'(ready_v[0]), 0);

    // 2: 5x5/K3 with continuous valid
    s_ce = ce_cnt[1]; s_win = win_cnt[1]; s_wlc = wl_cyc_cnt[1]; s_wr = wl_rise_cnt[1];
    s_wae = wl_addr_err[1]; s_mis = misalign[1]; s_seq = seq_err[1];
    start_pass(1);
    wait_done(1, 1'b0);
    chk("t2_wload_cycles", wl_cyc_cnt[1] - s_wlc, 9);
    chk("t2_wload_runs", wl_rise_cnt[1] - s_wr, 1);
    chk("t2_waddr_seq_err", wl_addr_err[1] - s_wae, 0);
    chk("t2_start_to_load", wl_rise_cyc[1] - st_cyc, 1);
    chk("t2_ce_count", ce_cnt[1] - s_ce, 25);
    chk("t2_win_count", win_cnt[1] - s_win, 9);
    chk("t2_first_win_rc", first_rc[1], 0);
    chk("t2_last_win_rc", last_rc[1], 2*256+2);
    chk("t2_coord_seq_err", seq_err[1] - s_seq, 0);
    chk("t2_strobe_align_err", misalign[1] - s_mis, 0);
    chk("t2_done_after_last", done_cyc[1] - last_acc_cyc[1], 4);
    @(negedge clk); #1;
    chk("t2_busy_after_done", int'(busy_v[1]), 0);
    chk("t2_coord_hold", int'({row_v[1], col_v[1]}), 2*256+2);

    // 3: same pass with random stalls
    s_ce = ce_cnt[1]; s_win = win_cnt[1]; s_mis = misalign[1]; s_seq = seq_err[1];
    start_pass(1);
    wait_done(1, 1'b1);
    chk("t3_ce_count", ce_cnt[1] - s_ce, 25);
    chk("t3_win_count", win_cnt[1] - s_win, 9);
    chk("t3_coord_seq_err", seq_err[1] - s_seq, 0);
    chk("t3_strobe_align_err", misalign[1] - s_mis, 0);
    chk("t3_first_win_rc", first_rc[1], 0);
    chk("t3_last_win_rc", last_rc[1], 2*256+2);

    // 4: reset after pixel 12 aborts the pass
    s_acc = acc_cnt[1]; s_done = done_cnt[1];
    start_pass(1);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk); #1;
      if (acc_cnt[1] - s_acc >= 13) hit = 1'b1;
    end
    chk("t4_reached_px12", int'(hit), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("t4_busy_after_rst", int'(busy_v[1]), 0);
    chk("t4_ce_after_rst", int'(ce_v[1]), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_no_done", done_cnt[1] - s_done, 0);
    s_ce = ce_cnt[1]; s_win = win_cnt[1];
    start_pass(1);
    wait_done(1, 1'b0);
    chk("t4_rerun_ce", ce_cnt[1] - s_ce, 25);
    chk("t4_rerun_win", win_cnt[1] - s_win, 9);

    // 5: start held high across two passes
    s_ce = ce_cnt[1]; s_win = win_cnt[1]; s_wr = wl_rise_cnt[1];
    @(posedge clk); #1;
    start_v[1] = 1'b1;
    wait_done(1, 1'b0);
    chk("t5_one_load_per_pass", wl_rise_cnt[1] - s_wr, 1);
    d1 = done_cyc[1];
    hit = 1'b0;
    for (int n = 0; n < 10 && !hit; n++) begin
      @(posedge clk); #1;
      if (wl_rise_cnt[1] - s_wr >= 2) hit = 1'b1;
    end
    chk("t5_restart_gap", wl_rise_cyc[1] - d1, 2);
    start_v[1] = 1'b0;
    wait_done(1, 1'b0);
    chk("t5_ce_two_passes", ce_cnt[1] - s_ce, 50);
    chk("t5_win_two_passes", win_cnt[1] - s_win, 18);
    chk("t5_loads_two_passes", wl_rise_cnt[1] - s_wr, 2);

    // 6a: K=1, 4x4 -> every pixel is a window
    s_ce = ce_cnt[2]; s_win = win_cnt[2]; s_seq = seq_err[2]; s_wlc = wl_cyc_cnt[2];
    start_pass(2);
    wait_done(2, 1'b0);
    chk("t6a_wload_cycles", wl_cyc_cnt[2] - s_wlc, 1);
    chk("t6a_ce_count", ce_cnt[2] - s_ce, 16);
    chk("t6a_win_count", win_cnt[2] - s_win, 16);
    chk("t6a_first_win_rc", first_rc[2], 0);
    chk("t6a_last_win_rc", last_rc[2], 3*256+3);
    chk("t6a_coord_seq_err", seq_err[2] - s_seq, 0);

    // 6b: IF_SIZE=K=3 -> single window on the last pixel
    s_ce = ce_cnt[3]; s_win = win_cnt[3]; s_mis = misalign[3];
    start_pass(3);
    wait_done(3, 1'b0);
    chk("t6b_ce_count", ce_cnt[3] - s_ce, 9);
    chk("t6b_win_count", win_cnt[3] - s_win, 1);
    chk("t6b_win_rc", first_rc[3], 0);
    chk("t6b_win_on_ce_index", win_ce_idx[3] - s_ce, 9);
    chk("t6b_strobe_align_err", misalign[3] - s_mis, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
